// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RV32I-subset core: opcodes, function
// fields, ALU operation and immediate-format enums, and the immediate builder.
package cpu_pkg;

  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 256;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B
  } imm_fmt_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     mem_read;
    logic     branch;
    logic     use_imm;
    alu_op_e  alu_op;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  // B-format keeps an implicit zero LSB, giving a 13-bit even offset.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU: two operands and an operation code in, result and
// zero flag out. The zero flag drives the beq decision.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  alu_op_e op;
  assign op = alu_op_e'(op_i);

  always_comb begin
    result_o = 32'h0;
    case (op)
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_MUL: result_o = a_i * b_i;
      ALU_SRA: result_o = $signed(a_i) >>> b_i[4:0];
      default: result_o = 32'h0;
    endcase
  end

  assign zero_o = (result_o == 32'h0);

endmodule

// File: rtl/cpu_core_units.sv
// Storage and control units of the core: program counter, instruction and
// data memories, register file and the instruction decoder.
module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] next_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= 32'h0;
    end else if (en_i) begin
      pc_q <= next_pc_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// Read-only program store; contents are placed by the environment before a run.
module cpu_imem
  import cpu_pkg::*;
(
  input  logic [7:0]  addr_i,
  output logic [31:0] instr_o
);

  logic [31:0] memory [0:IMEM_WORDS-1];

  assign instr_o = memory[addr_i];

endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (rd_i != 5'd0)) begin
      register[rd_i] <= wd_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1_o = (rs1_i == 5'd0) ? 32'h0 : register[rs1_i];
  assign rd2_o = (rs2_i == 5'd0) ? 32'h0 : register[rs2_i];

endmodule

module cpu_dmem
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] memory [0:DMEM_WORDS-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[addr_i];

endmodule

module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       mem_read_o,
  output logic       branch_o,
  output logic       use_imm_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] imm_fmt_o
);

  ctrl_t ctrl;

  // Anything not matched below falls through as a NOP with all enables low.
  always_comb begin
    ctrl = '{reg_write: 1'b0, mem_write: 1'b0, mem_read: 1'b0, branch: 1'b0,
             use_imm: 1'b0, alu_op: ALU_ADD, imm_fmt: IMM_NONE};
    case (opcode_i)
      OP_RTYPE: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            F3_ADD_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
            F3_SLL:     begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SLL; end
            F3_XOR:     begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_XOR; end
            F3_AND:     begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
            default:    ctrl.reg_write = 1'b0;
          endcase
        end else if (funct7_i == F7_ALT && funct3_i == F3_ADD_SUB) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_SUB;
        end else if (funct7_i == F7_MULDIV && funct3_i == F3_ADD_SUB) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_MUL;
        end
      end
      OP_ITYPE: begin
        ctrl.use_imm = 1'b1;
        ctrl.imm_fmt = IMM_I;
        if (funct3_i == F3_ADD_SUB) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end else if (funct3_i == F3_SRA && funct7_i == F7_ALT) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALU_SRA;
        end
      end
      OP_LOAD: begin
        if (funct3_i == F3_WORD) begin
          ctrl.reg_write = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.use_imm   = 1'b1;
          ctrl.imm_fmt   = IMM_I;
        end
      end
      OP_STORE: begin
        if (funct3_i == F3_WORD) begin
          ctrl.mem_write = 1'b1;
          ctrl.use_imm   = 1'b1;
          ctrl.imm_fmt   = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (funct3_i == F3_BEQ) begin
          ctrl.branch  = 1'b1;
          ctrl.alu_op  = ALU_SUB;
          ctrl.imm_fmt = IMM_B;
        end
      end
      default: ctrl.reg_write = 1'b0;
    endcase
  end

  assign reg_write_o = ctrl.reg_write;
  assign mem_write_o = ctrl.mem_write;
  assign mem_read_o  = ctrl.mem_read;
  assign branch_o    = ctrl.branch;
  assign use_imm_o   = ctrl.use_imm;
  assign alu_op_o    = ctrl.alu_op;
  assign imm_fmt_o   = ctrl.imm_fmt;

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory access and
// write-back all complete within one clock while start_i is high.
module cpu_core
  import cpu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic        reg_write;
  logic        mem_write;
  logic        mem_read;
  logic        branch;
  logic        use_imm;
  logic        alu_zero;
  logic        wr_en;
  logic [2:0]  alu_op;
  logic [1:0]  imm_fmt;

  // Architectural writes happen only on executing cycles, never while reset is held.
  assign wr_en = start_i & ~rst_i;

  cpu_pc PC (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (start_i),
    .next_pc_i (next_pc),
    .pc_o      (pc)
  );

  cpu_imem Instruction_Memory (
    .addr_i  (pc[9:2]),
    .instr_o (instr)
  );

  cpu_decoder Decoder (
    .opcode_i    (instr[6:0]),
    .funct3_i    (instr[14:12]),
    .funct7_i    (instr[31:25]),
    .reg_write_o (reg_write),
    .mem_write_o (mem_write),
    .mem_read_o  (mem_read),
    .branch_o    (branch),
    .use_imm_o   (use_imm),
    .alu_op_o    (alu_op),
    .imm_fmt_o   (imm_fmt)
  );

  cpu_regfile Registers (
    .clk_i (clk_i),
    .we_i  (wr_en & reg_write),
    .rs1_i (instr[19:15]),
    .rs2_i (instr[24:20]),
    .rd_i  (instr[11:7]),
    .wd_i  (wb_data),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data)
  );

  assign imm   = imm_gen(instr, imm_fmt_e'(imm_fmt));
  assign alu_b = use_imm ? imm : rs2_data;

  cpu_alu ALU (
    .a_i      (rs1_data),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  cpu_dmem Data_Memory (
    .clk_i   (clk_i),
    .we_i    (wr_en & mem_write),
    .addr_i  (alu_result[9:2]),
    .wdata_i (rs2_data),
    .rdata_o (mem_rdata)
  );

  assign wb_data = mem_read ? mem_rdata : alu_result;
  assign next_pc = (branch && alu_zero) ? (pc + imm) : (pc + 32'd4);

endmodule

// File: tb/tb_cpu_core.sv
// Randomized and directed checks of cpu_core against an instruction-level
// reference model that executes the same program word by word.
module tb_cpu_core;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic start_i = 1'b0;

  always #5 clk_i = ~clk_i;

  cpu_core dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_imem [256];
  logic [31:0] m_pc;
  logic [31:0] prog [$];

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    logic [4:0] a, b, d;
    a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0];
    return {f7, b, a, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    logic [4:0]  a, d;
    im = imm[11:0]; a = rs1[4:0]; d = rd[4:0];
    return {im, a, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_sw(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    logic [4:0]  a, b;
    im = imm[11:0]; a = rs1[4:0]; b = rs2[4:0];
    return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_beq(input int off, input int rs1, input int rs2);
    logic [12:0] im;
    logic [4:0]  a, b;
    im = off[12:0]; a = rs1[4:0]; b = rs2[4:0];
    return {im[12], im[10:5], b, a, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] lw(input int rd, input int imm);
    return enc_i(imm, 0, 3'b010, rd, 7'b0000011);
  endfunction

  // Reference semantics, one whole instruction per call, from mnemonic rules.
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, v, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          wr;
    ins = m_imem[m_pc[9:2]];
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    a  = m_reg[ins[19:15]];
    b  = m_reg[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    nxt = m_pc + 4;
    wr = 0;
    v  = 0;
    if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h00) begin wr = 1; v = a + b; end
    else if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20) begin wr = 1; v = a - b; end
    else if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h01) begin wr = 1; v = a * b; end
    else if (op == 7'b0110011 && f3 == 3'd7 && f7 == 7'h00) begin wr = 1; v = a & b; end
    else if (op == 7'b0110011 && f3 == 3'd4 && f7 == 7'h00) begin wr = 1; v = a ^ b; end
    else if (op == 7'b0110011 && f3 == 3'd1 && f7 == 7'h00) begin wr = 1; v = a << b[4:0]; end
    else if (op == 7'b0010011 && f3 == 3'd0) begin wr = 1; v = a + ii; end
    else if (op == 7'b0010011 && f3 == 3'd5 && f7 == 7'h20) begin wr = 1; v = $signed(a) >>> ins[24:20]; end
    else if (op == 7'b0000011 && f3 == 3'd2) begin wr = 1; v = m_dmem[((a + ii) >> 2) % 256]; end
    else if (op == 7'b0100011 && f3 == 3'd2) m_dmem[((a + is) >> 2) % 256] = b;
    else if (op == 7'b1100011 && f3 == 3'd0 && a == b) nxt = m_pc + ib;
    if (wr && rd != 0) m_reg[rd] = v;
    m_pc = nxt;
  endtask

  task automatic load_program();
    logic [31:0] w;
    start_i = 1'b0;
    rst_i   = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'h0;
      dut.Instruction_Memory.memory[i] = w;
      m_imem[i] = w;
    end
    #1 rst_i = 1'b0;
    m_pc = 32'h0;
  endtask

  task automatic run_steps(input int n);
    start_i = 1'b1;
    repeat (n) begin
      model_step();
      @(negedge clk_i);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      dut.Instruction_Memory.memory[i] = 32'h0;
      m_imem[i] = 32'h0;
    end
    m_reg[0] = 32'h0;
    start_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (dut.PC.pc_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %0d expected 0", dut.PC.pc_o);
    end
    rst_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      n_checks++;
      if (dut.PC.pc_o !== 32'(4 * k)) begin
        n_fail++; $display("FAIL reset_run_pc%0d: got %0d expected %0d", k, dut.PC.pc_o, 4 * k);
      end
    end
    start_i = 1'b0;
    $display("test_reset done");
  endtask

  // Prologue gives every register and data words 0..15 a defined value.
  task automatic test_reg_init();
    prog.delete();
    for (int i = 1; i < 32; i++) prog.push_back(addi(i, 0, int'($urandom_range(4095)) - 2048));
    for (int k = 0; k < 16; k++) prog.push_back(enc_sw(4 * k, k + 1, 0));
    load_program();
    run_steps(prog.size());
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== m_reg[i]) begin
        n_fail++; $display("FAIL init_x%0d: got %h expected %h", i, dut.Registers.register[i], m_reg[i]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (dut.Data_Memory.memory[k] !== m_dmem[k]) begin
        n_fail++; $display("FAIL init_mem%0d: got %h expected %h", k, dut.Data_Memory.memory[k], m_dmem[k]);
      end
    end
    $display("test_reg_init done");
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [1:5];
    exp_v[1] = 32'd5; exp_v[2] = -32'sd3; exp_v[3] = 32'd2; exp_v[4] = 32'd8; exp_v[5] = -32'sd15;
    prog.delete();
    prog.push_back(addi(1, 0, 5));
    prog.push_back(addi(2, 0, -3));
    prog.push_back(enc_r(7'h00, 2, 1, 3'd0, 3));
    prog.push_back(enc_r(7'h20, 2, 1, 3'd0, 4));
    prog.push_back(enc_r(7'h01, 2, 1, 3'd0, 5));
    load_program();
    run_steps(5);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== exp_v[i] || m_reg[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL alu_x%0d: got %h expected %h", i, dut.Registers.register[i], exp_v[i]);
      end
    end
    n_checks++;
    if (dut.PC.pc_o !== 32'd20) begin
      n_fail++; $display("FAIL alu_pc: got %0d expected 20", dut.PC.pc_o);
    end
    $display("test_alu done");
  endtask

  task automatic test_logic_shift();
    logic [31:0] exp_v [6:9];
    exp_v[6] = 32'd5; exp_v[7] = -32'sd8; exp_v[8] = 32'd160; exp_v[9] = -32'sd2;
    prog.delete();
    prog.push_back(enc_r(7'h00, 2, 1, 3'd7, 6));
    prog.push_back(enc_r(7'h00, 2, 1, 3'd4, 7));
    prog.push_back(enc_r(7'h00, 1, 1, 3'd1, 8));
    prog.push_back(enc_i({20'h0, 7'h20, 5'd1}, 2, 3'd5, 9, 7'b0010011));
    load_program();
    run_steps(4);
    for (int i = 6; i <= 9; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== exp_v[i]) begin
        n_fail++; $display("FAIL logic_x%0d: got %h expected %h", i, dut.Registers.register[i], exp_v[i]);
      end
    end
    $display("test_logic_shift done");
  endtask

  task automatic test_x0_nop();
    prog.delete();
    prog.push_back(addi(0, 0, 7));
    prog.push_back(enc_r(7'h00, 1, 0, 3'd0, 11));
    prog.push_back(32'h0);
    load_program();
    run_steps(2);
    n_checks++;
    if (dut.Registers.register[11] !== 32'd5) begin
      n_fail++; $display("FAIL x0_read: got %h expected 5", dut.Registers.register[11]);
    end
    run_steps(1);
    n_checks++;
    if (dut.PC.pc_o !== 32'd12) begin
      n_fail++; $display("FAIL nop_pc: got %0d expected 12", dut.PC.pc_o);
    end
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== m_reg[i]) begin
        n_fail++; $display("FAIL nop_x%0d: got %h expected %h", i, dut.Registers.register[i], m_reg[i]);
      end
    end
    $display("test_x0_nop done");
  endtask

  task automatic test_memory();
    prog.delete();
    prog.push_back(enc_sw(12, 2, 0));
    prog.push_back(enc_sw(8, 1, 0));
    prog.push_back(lw(10, 8));
    prog.push_back(lw(10, 12));
    prog.push_back(lw(15, 11));
    load_program();
    run_steps(3);
    n_checks++;
    if (dut.Registers.register[10] !== 32'd5) begin
      n_fail++; $display("FAIL mem_lw_same: got %h expected 5", dut.Registers.register[10]);
    end
    run_steps(2);
    n_checks++;
    if (dut.Registers.register[10] !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL mem_lw_other: got %h expected fffffffd", dut.Registers.register[10]);
    end
    n_checks++;
    if (dut.Registers.register[15] !== m_reg[15]) begin
      n_fail++; $display("FAIL mem_lowbits: got %h expected %h", dut.Registers.register[15], m_reg[15]);
    end
    $display("test_memory done");
  endtask

  task automatic test_branch();
    for (int variant = 0; variant < 2; variant++) begin
      prog.delete();
      prog.push_back(addi(1, 0, 5));
      prog.push_back(addi(2, 0, -3));
      repeat (3) prog.push_back(32'h0);
      prog.push_back(variant == 0 ? enc_beq(8, 1, 1) : enc_beq(8, 1, 2));
      prog.push_back(32'h0);
      prog.push_back(enc_beq(-28, 2, 2));
      load_program();
      run_steps(5);
      n_checks++;
      if (dut.PC.pc_o !== 32'd20) begin
        n_fail++; $display("FAIL br_pre%0d: got %0d expected 20", variant, dut.PC.pc_o);
      end
      run_steps(1);
      n_checks++;
      if (dut.PC.pc_o !== (variant == 0 ? 32'd28 : 32'd24)) begin
        n_fail++; $display("FAIL br_beq%0d: got %0d expected %0d", variant, dut.PC.pc_o,
                           variant == 0 ? 28 : 24);
      end
      run_steps(variant == 0 ? 1 : 2);
      n_checks++;
      if (dut.PC.pc_o !== m_pc) begin
        n_fail++; $display("FAIL br_back%0d: got %0d expected %0d", variant, dut.PC.pc_o, m_pc);
      end
    end
    $display("test_branch done");
  endtask

  task automatic test_hold();
    prog.delete();
    prog.push_back(addi(14, 14, 1));
    prog.push_back(addi(14, 14, 1));
    prog.push_back(enc_sw(0, 14, 0));
    prog.push_back(addi(14, 14, 1));
    load_program();
    run_steps(2);
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (dut.PC.pc_o !== 32'd8) begin
      n_fail++; $display("FAIL hold_pc: got %0d expected 8", dut.PC.pc_o);
    end
    n_checks++;
    if (dut.Registers.register[14] !== m_reg[14]) begin
      n_fail++; $display("FAIL hold_x14: got %h expected %h", dut.Registers.register[14], m_reg[14]);
    end
    n_checks++;
    if (dut.Data_Memory.memory[0] !== m_dmem[0]) begin
      n_fail++; $display("FAIL hold_mem: got %h expected %h", dut.Data_Memory.memory[0], m_dmem[0]);
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_midrun();
    prog.delete();
    repeat (8) prog.push_back(addi(13, 13, 1));
    load_program();
    run_steps(3);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (dut.PC.pc_o !== 32'h0) begin
      n_fail++; $display("FAIL midrst_pc_now: got %0d expected 0", dut.PC.pc_o);
    end
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n_checks++;
    if (dut.PC.pc_o !== 32'h0 || dut.Registers.register[13] !== m_reg[13]) begin
      n_fail++; $display("FAIL midrst_hold: got pc %0d x13 %h expected pc 0 x13 %h",
                         dut.PC.pc_o, dut.Registers.register[13], m_reg[13]);
    end
    rst_i = 1'b0;
    m_pc = 32'h0;
    run_steps(2);
    n_checks++;
    if (dut.PC.pc_o !== 32'd8 || dut.Registers.register[13] !== m_reg[13]) begin
      n_fail++; $display("FAIL midrst_resume: got pc %0d x13 %h expected pc 8 x13 %h",
                         dut.PC.pc_o, dut.Registers.register[13], m_reg[13]);
    end
    $display("test_reset_midrun done");
  endtask

  function automatic logic [31:0] rand_instr();
    int rd, rs1, rs2, w;
    logic [6:0] bad_ops [4];
    bad_ops[0] = 7'b0110111; bad_ops[1] = 7'b0010111; bad_ops[2] = 7'b1101111; bad_ops[3] = 7'b0000000;
    rd = int'($urandom_range(31)); rs1 = int'($urandom_range(31)); rs2 = int'($urandom_range(31));
    w = int'($urandom_range(15));
    case ($urandom_range(11))
      0:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);
      1:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);
      2:  return enc_r(7'h01, rs2, rs1, 3'd0, rd);
      3:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);
      4:  return enc_r(7'h00, rs2, rs1, 3'd4, rd);
      5:  return enc_r(7'h00, rs2, rs1, 3'd1, rd);
      6:  return addi(rd, rs1, int'($urandom_range(4095)) - 2048);
      7:  return enc_i({20'h0, 7'h20, 5'(rs2)}, rs1, 3'd5, rd, 7'b0010011);
      8:  return lw(rd, 4 * w + int'($urandom_range(3)));
      9:  return enc_sw(4 * w + int'($urandom_range(3)), rs2, 0);
      10: return enc_beq(4 * (int'($urandom_range(6)) - 2), rs1, $urandom_range(1) ? rs1 : rs2);
      default: return {$urandom_range(1) ? 7'h20 : 7'h7f, 18'($urandom()), bad_ops[$urandom_range(3)]};
    endcase
  endfunction

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      prog.delete();
      repeat (60) prog.push_back(rand_instr());
      load_program();
      run_steps(60);
      n_checks++;
      if (dut.PC.pc_o !== m_pc) begin
        n_fail++; $display("FAIL rnd%0d_pc: got %h expected %h", round, dut.PC.pc_o, m_pc);
      end
      for (int i = 1; i < 32; i++) begin
        n_checks++;
        if (dut.Registers.register[i] !== m_reg[i]) begin
          n_fail++; $display("FAIL rnd%0d_x%0d: got %h expected %h", round, i,
                             dut.Registers.register[i], m_reg[i]);
        end
      end
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (dut.Data_Memory.memory[k] !== m_dmem[k]) begin
          n_fail++; $display("FAIL rnd%0d_mem%0d: got %h expected %h", round, k,
                             dut.Data_Memory.memory[k], m_dmem[k]);
        end
      end
      $display("test_random round %0d done", round);
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_reg_init();
    test_alu();
    test_logic_shift();
    test_x0_nop();
    test_memory();
    test_branch();
    test_hold();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
